// File: rtl/clk_mon_pkg.sv
// Shared definitions for the PLL lock monitor: state encoding and default
// window sizing for a 50 MHz system clock and a 12.5 MHz divided PLL output.
`timescale 1ns/1ps
package clk_mon_pkg;

    typedef enum logic [1:0] {
        S_RST  = 2'd0,
        S_ACQ  = 2'd1,
        S_LOCK = 2'd2
    } state_e;

    localparam int unsigned SYS_CLK_HZ      = 50_000_000;
    localparam int unsigned MEAS_HZ         = 12_500_000;
    // 20 us gate window at 50 MHz
    localparam int unsigned GATE_CYCLES_DEF = SYS_CLK_HZ / 50_000;
    localparam int unsigned EXP_COUNT_DEF   = GATE_CYCLES_DEF / (SYS_CLK_HZ / MEAS_HZ);

endpackage

// File: rtl/sync_edge_det.sv
// Two-flop synchronizer for an asynchronous input plus a rising-edge pulse
// taken from the synchronized level.
`timescale 1ns/1ps
module sync_edge_det (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic rise
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            meta_q <= async_in;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign rise = sync_q & ~prev_q;

endmodule

// File: rtl/clk_lock_monitor.sv
// Frequency-based PLL lock checker: counts divided PLL edges per gate window,
// qualifies lock over consecutive good windows and drives the PLL reset.
`timescale 1ns/1ps
module clk_lock_monitor
    import clk_mon_pkg::*;
#(
    parameter int unsigned CNT_W        = 16,
    parameter int unsigned GATE_CYCLES  = GATE_CYCLES_DEF,
    parameter int unsigned EXP_COUNT    = EXP_COUNT_DEF,
    parameter int unsigned TOL          = 2,
    parameter int unsigned GOOD_WINDOWS = 4,
    parameter int unsigned MAX_TRIES    = 8,
    parameter int unsigned RST_PULSE    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             meas_in,
    input  logic             auto_rst,
    output logic             pll_rst,
    output logic             locked,
    output logic             lock_lost,
    output logic [CNT_W-1:0] freq_count,
    output logic             count_valid
);

    localparam int unsigned WIN_W  = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
    localparam int unsigned GOOD_W = $clog2(GOOD_WINDOWS + 1);
    localparam int unsigned TRY_W  = $clog2(MAX_TRIES + 1);
    localparam int unsigned RST_W  = $clog2(RST_PULSE + 1);
    localparam logic [CNT_W:0] TOL_C = (CNT_W + 1)'(TOL);

    state_e             state_q, state_d;
    logic [WIN_W-1:0]   win_q, win_d;
    logic [CNT_W-1:0]   edge_q, edge_d;
    logic [GOOD_W-1:0]  good_q, good_d;
    logic [TRY_W-1:0]   try_q, try_d;
    logic [RST_W-1:0]   rst_cnt_q, rst_cnt_d;
    logic               pll_rst_q, pll_rst_d;
    logic               locked_q, locked_d;
    logic               lock_lost_q, lock_lost_d;
    logic [CNT_W-1:0]   freq_q, freq_d;
    logic               valid_q, valid_d;

    logic               rise;
    logic               win_last;
    logic [CNT_W-1:0]   edge_sum;
    logic signed [CNT_W:0] diff;
    logic [CNT_W:0]     mag;
    logic               win_good;

    sync_edge_det u_meas_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .async_in (meas_in),
        .rise     (rise)
    );

    // Saturating count including the edge flagged in the current cycle
    assign edge_sum = edge_q + CNT_W'(rise && (edge_q != '1));
    assign win_last = (win_q == WIN_W'(GATE_CYCLES - 1));
    assign diff     = $signed({1'b0, edge_sum}) - $signed({1'b0, CNT_W'(EXP_COUNT)});
    assign mag      = diff[CNT_W] ? $unsigned(-diff) : $unsigned(diff);
    assign win_good = (mag <= TOL_C);

    always_comb begin
        state_d     = state_q;
        win_d       = win_q;
        edge_d      = edge_q;
        good_d      = good_q;
        try_d       = try_q;
        rst_cnt_d   = rst_cnt_q;
        pll_rst_d   = pll_rst_q;
        locked_d    = locked_q;
        lock_lost_d = 1'b0;
        freq_d      = freq_q;
        valid_d     = 1'b0;

        unique case (state_q)
            S_RST: begin
                pll_rst_d = 1'b1;
                locked_d  = 1'b0;
                win_d     = '0;
                edge_d    = '0;
                good_d    = '0;
                try_d     = '0;
                if (rst_cnt_q == RST_W'(RST_PULSE - 1)) begin
                    rst_cnt_d = '0;
                    pll_rst_d = 1'b0;
                    state_d   = S_ACQ;
                end else begin
                    rst_cnt_d = rst_cnt_q + 1'b1;
                end
            end
            S_ACQ, S_LOCK: begin
                if (win_last) begin
                    win_d   = '0;
                    edge_d  = '0;
                    freq_d  = edge_sum;
                    valid_d = 1'b1;
                    if (state_q == S_ACQ) begin
                        if (win_good) begin
                            if (good_q == GOOD_W'(GOOD_WINDOWS - 1)) begin
                                state_d  = S_LOCK;
                                locked_d = 1'b1;
                                good_d   = '0;
                                try_d    = '0;
                            end else begin
                                good_d = good_q + 1'b1;
                            end
                        end else begin
                            good_d = '0;
                            if (try_q == TRY_W'(MAX_TRIES - 1)) begin
                                state_d   = S_RST;
                                pll_rst_d = 1'b1;
                                try_d     = '0;
                            end else begin
                                try_d = try_q + 1'b1;
                            end
                        end
                    end else if (!win_good) begin
                        locked_d    = 1'b0;
                        lock_lost_d = 1'b1;
                        good_d      = '0;
                        try_d       = '0;
                        if (auto_rst) begin
                            state_d   = S_RST;
                            pll_rst_d = 1'b1;
                        end else begin
                            state_d = S_ACQ;
                        end
                    end
                end else begin
                    win_d  = win_q + 1'b1;
                    edge_d = edge_sum;
                end
            end
            default: begin
                state_d   = S_RST;
                pll_rst_d = 1'b1;
                locked_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_RST;
            win_q       <= '0;
            edge_q      <= '0;
            good_q      <= '0;
            try_q       <= '0;
            rst_cnt_q   <= '0;
            pll_rst_q   <= 1'b1;
            locked_q    <= 1'b0;
            lock_lost_q <= 1'b0;
            freq_q      <= '0;
            valid_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            win_q       <= win_d;
            edge_q      <= edge_d;
            good_q      <= good_d;
            try_q       <= try_d;
            rst_cnt_q   <= rst_cnt_d;
            pll_rst_q   <= pll_rst_d;
            locked_q    <= locked_d;
            lock_lost_q <= lock_lost_d;
            freq_q      <= freq_d;
            valid_q     <= valid_d;
        end
    end

    assign pll_rst     = pll_rst_q;
    assign locked      = locked_q;
    assign lock_lost   = lock_lost_q;
    assign freq_count  = freq_q;
    assign count_valid = valid_q;

endmodule

// File: tb/tb_clk_lock_monitor.sv
// Scoreboard bench for clk_lock_monitor: a window-aligned edge generator sets
// the per-window edge count, expectations are queued and checked on count_valid.
`timescale 1ns/1ps
module tb_clk_lock_monitor;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        meas_in;
    logic        auto_rst;
    logic        pll_rst;
    logic        locked;
    logic        lock_lost;
    logic [15:0] freq_count;
    logic        count_valid;

    typedef struct {
        int cnt;
        bit lk;
        bit lost;
        bit rst;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;
    int   rate = 250;
    int   acc = 0;
    int   j = 0;
    int   bnd_cnt = 0;
    int   pulses = 0;
    int   bad_cnts[8] = '{0, 247, 253, 500, 100, 0, 260, 240};

    always #10 clk = ~clk;

    clk_lock_monitor dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .meas_in     (meas_in),
        .auto_rst    (auto_rst),
        .pll_rst     (pll_rst),
        .locked      (locked),
        .lock_lost   (lock_lost),
        .freq_count  (freq_count),
        .count_valid (count_valid)
    );

    // Phase accumulator: any 1000 consecutive samples at a fixed rate carry
    // exactly `rate` rising edges. A sample set in cycle k is flagged in k+2,
    // so a window starting at cycle c sees samples c-2 .. c+997.
    initial begin
        bit prev_rst;
        prev_rst = 1'b1;
        meas_in  = 1'b0;
        forever begin
            @(negedge clk);
            if (count_valid || (!pll_rst && prev_rst)) j = 0;
            else j++;
            prev_rst = pll_rst;
            acc += rate;
            if (acc >= 1000) begin
                acc -= 1000;
                meas_in = 1'b1;
            end else begin
                meas_in = 1'b0;
            end
            if (j == 997 && !pll_rst) bnd_cnt++;
        end
    end

    // Scoreboard monitor
    initial begin
        int   cyc;
        int   last_cv;
        bit   have_last;
        int   win_no;
        exp_t e;
        cyc = 0;
        last_cv = 0;
        have_last = 1'b0;
        win_no = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (pll_rst || !rst_n) have_last = 1'b0;
            if (count_valid) begin
                win_no++;
                if (have_last) begin
                    tests++;
                    if (cyc - last_cv != 1000) begin
                        fails++;
                        $display("FAIL cv_spacing win %0d: got %0d cycles, expected 1000",
                                 win_no, cyc - last_cv);
                    end
                end
                last_cv = cyc;
                have_last = 1'b1;
                tests++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_count_valid win %0d: got count=%0d, expected none",
                             win_no, freq_count);
                end else begin
                    e = exp_q.pop_front();
                    if (freq_count != 16'(e.cnt) || locked != e.lk || lock_lost != e.lost ||
                        pll_rst != e.rst) begin
                        fails++;
                        $display({"FAIL window %0d: got cnt=%0d locked=%0d lost=%0d rst=%0d, ",
                                  "expected cnt=%0d locked=%0d lost=%0d rst=%0d"},
                                 win_no, freq_count, locked, lock_lost, pll_rst,
                                 e.cnt, e.lk, e.lost, e.rst);
                    end
                end
            end
        end
    end

    // PLL reset pulse width, measured in cycles with rst_n released
    initial begin
        int width;
        width = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                width = 0;
            end else if (pll_rst) begin
                width++;
            end else if (width != 0) begin
                tests++;
                pulses++;
                if (width != 16) begin
                    fails++;
                    $display("FAIL pll_rst_width: got %0d cycles, expected 16", width);
                end
                width = 0;
            end
        end
    end

    task automatic chk(input string name, input int act, input int expv);
        tests++;
        if (act != expv) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, expv);
        end
    endtask

    task automatic push(input int c, input bit lk, input bit lost, input bit r);
        exp_t e;
        e.cnt  = c;
        e.lk   = lk;
        e.lost = lost;
        e.rst  = r;
        exp_q.push_back(e);
    endtask

    // Program the edge rate of the next window and queue its expected result
    task automatic win(input int n, input int c, input bit lk, input bit lost, input bit r);
        int last;
        int k;
        last = bnd_cnt;
        k = 0;
        while (bnd_cnt == last && k < 3000) begin
            @(negedge clk);
            #1;
            k++;
        end
        chk("window_boundary_seen", int'(bnd_cnt != last), 1);
        rate = n;
        push(c, lk, lost, r);
    endtask

    // Program the first window after a PLL reset pulse
    task automatic rst_win(input int n, input int c, input bit lk, input bit lost, input bit r);
        int k;
        k = 0;
        while (!pll_rst && k < 3000) begin
            @(negedge clk);
            #1;
            k++;
        end
        chk("pll_rst_seen", int'(pll_rst), 1);
        rate = n;
        push(c, lk, lost, r);
    endtask

    initial begin
        int k;
        rst_n    = 1'b0;
        auto_rst = 1'b0;
        rate     = 250;
        #50;
        chk("reset_pll_rst", int'(pll_rst), 1);
        chk("reset_locked", int'(locked), 0);
        chk("reset_lock_lost", int'(lock_lost), 0);
        chk("reset_freq_count", int'(freq_count), 0);
        chk("reset_count_valid", int'(count_valid), 0);
        push(250, 0, 0, 0);
        #50;
        @(posedge clk);
        #2;
        rst_n = 1'b1;

        // Start-up lock
        win(250, 250, 0, 0, 0);
        win(250, 250, 0, 0, 0);
        win(250, 250, 1, 0, 0);

        // Loss of lock with PLL reset
        win(0, 0, 0, 1, 1);
        auto_rst = 1'b1;
        rst_win(250, 250, 0, 0, 0);
        win(250, 250, 0, 0, 0);
        win(250, 250, 0, 0, 0);
        win(250, 250, 1, 0, 0);

        // Loss of lock back to acquire only
        win(500, 500, 0, 1, 0);
        auto_rst = 1'b0;

        // Tolerance boundaries while acquiring
        win(248, 248, 0, 0, 0);
        win(252, 252, 0, 0, 0);
        win(247, 247, 0, 0, 0);
        win(253, 253, 0, 0, 0);
        win(252, 252, 0, 0, 0);
        win(248, 248, 0, 0, 0);
        win(250, 250, 0, 0, 0);
        win(252, 252, 1, 0, 0);

        // Acquire timeout after MAX_TRIES bad windows
        win(0, 0, 0, 1, 0);
        for (int i = 0; i < 8; i++) begin
            win(bad_cnts[i], bad_cnts[i], 0, 0, (i == 7));
        end
        rst_win(250, 250, 0, 0, 0);
        win(250, 250, 0, 0, 0);
        win(250, 250, 0, 0, 0);
        win(250, 250, 1, 0, 0);

        // Asynchronous reset mid-window while locked
        win(250, 250, 1, 0, 0);
        repeat (500) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_locked", int'(locked), 0);
        chk("async_freq_count", int'(freq_count), 0);
        chk("async_pll_rst", int'(pll_rst), 1);
        chk("async_count_valid", int'(count_valid), 0);
        exp_q.delete();
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b1;
        rst_win(250, 250, 0, 0, 0);
        win(250, 250, 0, 0, 0);
        win(250, 250, 0, 0, 0);
        win(250, 250, 1, 0, 0);

        k = 0;
        while (exp_q.size() != 0 && k < 3000) begin
            @(negedge clk);
            k++;
        end
        chk("scoreboard_drained", exp_q.size(), 0);
        repeat (5) @(negedge clk);
        chk("pll_rst_pulses", pulses, 4);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
